carfield_l2_port_router: RTL

- Sits directly upstream of the dual-port L2 memory.
- Takes one request stream (host crossbar slave side) and decodes the address into L2 port 0, L2 port 1, or a decode error.
- Forwards each request to the selected port as a port-relative offset.
- Tracks outstanding transactions so responses return to the requester in issue order, even when the two ports answer out of relative order.

---
 rtl/carfield_pkg.sv | 19 +
 rtl/carfield_l2_rsp_fifo.sv | 41 ++++
 rtl/carfield_l2_port_router.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/carfield_pkg.sv
// Shared types and default address map for the Carfield L2 port router.
package carfield_pkg;

  localparam int unsigned L2_DATA_W     = 64;
  localparam logic [63:0] L2_PORT0_BASE = 64'h0000_0000_7800_0000;
  localparam logic [63:0] L2_PORT_SIZE  = 64'h0000_0000_0020_0000;

  typedef enum logic [1:0] {
    TGT_P0  = 2'd0,
    TGT_P1  = 2'd1,
    TGT_ERR = 2'd2
  } tgt_e;

  typedef struct packed {
    logic [L2_DATA_W-1:0] rdata;
    logic                 err;
  } rsp_t;

endpackage

// File: rtl/carfield_l2_rsp_fifo.sv
// Small synchronous FIFO; the caller guarantees no push into a full FIFO unless it pops too.
module carfield_l2_rsp_fifo #(
  parameter int unsigned Depth = 4,
  parameter type data_t = logic [7:0]
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push_i,
  input  data_t data_i,
  input  logic  pop_i,
  output data_t data_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW:0] wr_ptr, rd_ptr;
  data_t         mem [Depth];

  // Extra pointer MSB tells a full FIFO apart from an empty one.
  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[PtrW] != rd_ptr[PtrW]) &&
                   (wr_ptr[PtrW-1:0] == rd_ptr[PtrW-1:0]);
  assign data_o  = mem[rd_ptr[PtrW-1:0]];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i && !empty_o) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr[PtrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/carfield_l2_port_router.sv
// Decodes one request stream onto the two L2 ports and returns responses in issue order.
module carfield_l2_port_router
  import carfield_pkg::*;
#(
  parameter int unsigned          AddrWidth      = 64,
  parameter int unsigned          DataWidth      = L2_DATA_W,
  parameter logic [AddrWidth-1:0] Port0Base      = AddrWidth'(L2_PORT0_BASE),
  parameter logic [AddrWidth-1:0] PortSize       = AddrWidth'(L2_PORT_SIZE),
  parameter bit                   Port1Enable    = 1'b1,
  parameter int unsigned          MaxOutstanding = 4,
  localparam int unsigned         OffWidth       = $clog2(PortSize),
  localparam int unsigned         BeWidth        = DataWidth / 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [AddrWidth-1:0]           req_addr_i,
  input  logic                           req_we_i,
  input  logic [DataWidth-1:0]           req_wdata_i,
  input  logic [BeWidth-1:0]             req_be_i,
  output logic                           rsp_valid_o,
  output logic [DataWidth-1:0]           rsp_rdata_o,
  output logic                           rsp_err_o,
  output logic [1:0]                     port_valid_o,
  input  logic [1:0]                     port_ready_i,
  output logic [1:0][OffWidth-1:0]       port_addr_o,
  output logic [1:0]                     port_we_o,
  output logic [1:0][DataWidth-1:0]      port_wdata_o,
  output logic [1:0][BeWidth-1:0]        port_be_o,
  input  logic [1:0]                     port_rsp_valid_i,
  input  logic [1:0][DataWidth-1:0]      port_rsp_rdata_i,
  input  logic [1:0]                     port_rsp_err_i
);

  localparam logic [AddrWidth-1:0] Port1Base = Port0Base + PortSize;
  localparam logic [AddrWidth-1:0] Port1End  = Port1Base + PortSize;

  tgt_e tgt, order_head;
  logic order_full, order_empty, order_push, order_pop;
  logic req_fire, err_bypass, rsp_fire, head_p1;
  logic [1:0] buf_full, buf_empty, buf_push, buf_pop, bypass;
  rsp_t buf_head [2];
  rsp_t port_rsp [2];
  rsp_t rsp_next;

  always_comb begin
    tgt = TGT_ERR;
    if (req_addr_i >= Port0Base && req_addr_i < Port1Base) begin
      tgt = TGT_P0;
    end else if (Port1Enable && req_addr_i >= Port1Base && req_addr_i < Port1End) begin
      tgt = TGT_P1;
    end
  end

  always_comb begin
    case (tgt)
      TGT_P0:  req_ready_o = port_ready_i[0] && !order_full;
      TGT_P1:  req_ready_o = port_ready_i[1] && !order_full;
      default: req_ready_o = !order_full;
    endcase
  end

  assign req_fire        = req_valid_i && req_ready_o;
  assign port_valid_o[0] = req_valid_i && !order_full && (tgt == TGT_P0);
  assign port_valid_o[1] = req_valid_i && !order_full && (tgt == TGT_P1);
  assign port_addr_o[0]  = OffWidth'(req_addr_i - Port0Base);
  assign port_addr_o[1]  = OffWidth'(req_addr_i - Port1Base);
  assign port_we_o       = {2{req_we_i}};
  assign port_wdata_o    = {2{req_wdata_i}};
  assign port_be_o       = {2{req_be_i}};

  // A head whose data is already waiting (buffered, arriving now, or an error
  // accepted into an empty order FIFO) is answered on the very next edge.
  always_comb begin
    rsp_fire   = 1'b0;
    rsp_next   = '0;
    buf_pop    = '0;
    bypass     = '0;
    err_bypass = 1'b0;
    head_p1    = (order_head == TGT_P1);
    if (!order_empty) begin
      if (order_head == TGT_ERR) begin
        rsp_fire = 1'b1;
        rsp_next = '{rdata: '0, err: 1'b1};
      end else if (!buf_empty[head_p1]) begin
        rsp_fire         = 1'b1;
        rsp_next         = buf_head[head_p1];
        buf_pop[head_p1] = 1'b1;
      end else if (port_rsp_valid_i[head_p1]) begin
        rsp_fire        = 1'b1;
        rsp_next        = port_rsp[head_p1];
        bypass[head_p1] = 1'b1;
      end
    end else if (req_fire && tgt == TGT_ERR) begin
      rsp_fire   = 1'b1;
      rsp_next   = '{rdata: '0, err: 1'b1};
      err_bypass = 1'b1;
    end
  end

  assign order_push = req_fire && !err_bypass;
  assign order_pop  = rsp_fire && !err_bypass;

  carfield_l2_rsp_fifo #(
    .Depth  (MaxOutstanding),
    .data_t (tgt_e)
  ) i_order_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (order_push),
    .data_i  (tgt),
    .pop_i   (order_pop),
    .data_o  (order_head),
    .full_o  (order_full),
    .empty_o (order_empty)
  );

  for (genvar p = 0; p < 2; p++) begin : g_port_buf
    assign port_rsp[p] = '{rdata: L2_DATA_W'(port_rsp_rdata_i[p]), err: port_rsp_err_i[p]};
    assign buf_push[p] = port_rsp_valid_i[p] && !bypass[p] && (!buf_full[p] || buf_pop[p]);

    carfield_l2_rsp_fifo #(
      .Depth  (MaxOutstanding),
      .data_t (rsp_t)
    ) i_rsp_buf (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (buf_push[p]),
      .data_i  (port_rsp[p]),
      .pop_i   (buf_pop[p]),
      .data_o  (buf_head[p]),
      .full_o  (buf_full[p]),
      .empty_o (buf_empty[p])
    );
  end

  // Response register stage
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      rsp_valid_o <= rsp_fire;
      rsp_rdata_o <= DataWidth'(rsp_next.rdata);
      rsp_err_o   <= rsp_next.err;
    end
  end

endmodule
